// File: rtl/timer_arbiter.sv
// Purpose: arbitrates one shared countdown timer between two requesters and generates its decrement tick.
// Latency: request seen in IDLE -> LOAD next cycle, RUN the cycle after; done pulses one cycle after timer_out hits 0.
// Backpressure: a losing requester holds req and is served on the next IDLE visit; dropping req while owner aborts.
module timer_arbiter #(
    parameter int TICK_DIV = 100_000_000,
    parameter int W        = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] dur0,
    output logic         gnt0,
    output logic         done0,
    input  logic         req1,
    input  logic [W-1:0] dur1,
    output logic         gnt1,
    output logic         done1,
    output logic         busy,
    output logic         timer_load,
    output logic         timer_en,
    output logic [W-1:0] timer_init,
    input  logic [W-1:0] timer_out
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state;
    logic          owner;     // 0: requester 0 holds the timer, 1: requester 1
    logic          last;      // most recent owner; loses a tie
    logic [W-1:0]  dur_q;     // interval latched at grant time
    logic [PW-1:0] prescaler;

    logic in_load;
    logic in_run;
    logic in_done;
    logic active;
    logic tick;
    logic owner_req;
    logic pick1;

    assign in_load   = (state == LOAD);
    assign in_run    = (state == RUN);
    assign in_done   = (state == DONE);
    assign active    = in_load | in_run | in_done;
    assign tick      = (prescaler == PW'(TICK_DIV - 1));
    assign owner_req = owner ? req1 : req0;
    // Requester 1 wins if it is alone, or on a tie when requester 0 went last.
    assign pick1     = req1 & (~req0 | ~last);

    // Arbitration FSM, interval latch and 1 s prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            dur_q     <= '0;
            prescaler <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        owner <= pick1;
                        dur_q <= pick1 ? dur1 : dur0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    prescaler <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    prescaler <= tick ? '0 : prescaler + PW'(1);
                    // Expiry beats abort when both happen in the same cycle.
                    if (timer_out == '0) begin
                        state <= DONE;
                    end else if (!owner_req) begin
                        last  <= owner;
                        state <= IDLE;
                    end
                end
                DONE: begin
                    last  <= owner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt0       = active & ~owner;
    assign gnt1       = active & owner;
    assign done0      = in_done & ~owner;
    assign done1      = in_done & owner;
    assign busy       = active;
    assign timer_load = in_load;
    assign timer_init = in_load ? dur_q : '0;
    // Never decrement once the count has reached zero; DONE takes over.
    assign timer_en   = in_run & tick & (timer_out != '0);

endmodule

// File: tb/tb_timer_arbiter.sv
// Purpose: randomized two-requester traffic against an interval-arithmetic reference model.
// Latency: outputs checked every cycle on the falling edge.
// Backpressure: requesters hold, withdraw or re-request at random; mid-run resets included.
module tb_timer_arbiter;

    localparam int TD = 4;
    localparam int W  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] dur0, dur1;
    logic         gnt0, gnt1, done0, done1, busy;
    logic         timer_load, timer_en;
    logic [W-1:0] timer_init;
    logic [W-1:0] timer_out;
    logic [W-1:0] tcount = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model of the current grant: LOAD cycle, interval, owner.
    bit m_act;
    int m_g;
    int m_D;
    bit m_own;
    bit m_last;

    always #5 clk = ~clk;

    timer_arbiter #(.TICK_DIV(TD), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .dur0       (dur0),
        .gnt0       (gnt0),
        .done0      (done0),
        .req1       (req1),
        .dur1       (dur1),
        .gnt1       (gnt1),
        .done1      (done1),
        .busy       (busy),
        .timer_load (timer_load),
        .timer_en   (timer_en),
        .timer_init (timer_init),
        .timer_out  (timer_out)
    );

    // Shared countdown timer.
    assign timer_out = tcount;
    always @(posedge clk) begin
        if (timer_load)
            tcount <= timer_init;
        else if (timer_en && tcount != 0)
            tcount <= tcount - 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".gnt0"},  gnt0, 0);
        check({tag, ".gnt1"},  gnt1, 0);
        check({tag, ".done0"}, done0, 0);
        check({tag, ".done1"}, done1, 0);
        check({tag, ".busy"},  busy, 0);
        check({tag, ".load"},  timer_load, 0);
        check({tag, ".en"},    timer_en, 0);
        check({tag, ".init"},  timer_init, 0);
    endtask

    initial begin
        bit e_load, e_run, e_done, e_en;
        int rel;
        int e_init;

        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        dur0 = '0;
        dur1 = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst    = 1'b0;
        m_act  = 0;
        m_last = 1;
        m_g    = 0;
        m_D    = 0;
        m_own  = 0;

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            cyc = n;
            rst = 1'b0;

            // Expected outputs derived from position within the current interval.
            rel    = n - m_g;
            e_load = m_act && rel == 0;
            e_run  = m_act && rel >= 1 && rel <= TD * m_D + 1;
            e_done = m_act && rel == TD * m_D + 2;
            e_en   = e_run && rel >= TD && (rel % TD) == 0 && rel <= TD * m_D;
            e_init = e_load ? m_D : 0;

            check("gnt0",  gnt0,  m_act && !m_own);
            check("gnt1",  gnt1,  m_act && m_own);
            check("done0", done0, e_done && !m_own);
            check("done1", done1, e_done && m_own);
            check("busy",  busy,  m_act);
            check("load",  timer_load, e_load);
            check("en",    timer_en, e_en);
            check("init",  timer_init, e_init);

            // Requester behaviour for the next edge.
            if (n == 0) begin
                req0 = 1'b1; dur0 = 4'd2;
                req1 = 1'b1; dur1 = 4'd1;
            end else begin
                if (e_done && !m_own) req0 = ($urandom % 3) == 0;
                else if (!req0)       req0 = ($urandom % 4) == 0;
                else if (($urandom % 40) == 0) req0 = 1'b0;
                if (e_done && m_own)  req1 = ($urandom % 3) == 0;
                else if (!req1)       req1 = ($urandom % 4) == 0;
                else if (($urandom % 40) == 0) req1 = 1'b0;
                if (($urandom % 5) == 0) dur0 = W'($urandom_range(0, 4));
                if (($urandom % 5) == 0) dur1 = W'($urandom_range(0, 4));
            end

            if (n == 700 || n == 1900 || n == 2500) begin
                // Asynchronous reset between edges: outputs must drop at once.
                #2 rst = 1'b1;
                #1 check_all_zero("midrst");
                m_act  = 0;
                m_last = 1;
            end else if (!m_act) begin
                if (req0 || req1) begin
                    m_own = (req0 && req1) ? !m_last : req1;
                    m_D   = m_own ? int'(dur1) : int'(dur0);
                    m_g   = n + 1;
                    m_act = 1;
                end
            end else if (rel >= 1 && rel <= TD * m_D) begin
                if (!(m_own ? req1 : req0)) begin
                    m_act  = 0;
                    m_last = m_own;
                end
            end else if (rel == TD * m_D + 2) begin
                m_act  = 0;
                m_last = m_own;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
